// File: rtl/palin_pkg.sv
// rtl/palin_pkg.sv - shared state type, stat width and round-robin helper for palin_check_sched
package palin_pkg;

   localparam int STAT_W = 16;
   localparam int RR_MAX = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } rr_pick_t;

   // Scans from the farthest candidate back to the nearest one after last, so the nearest hit is kept.
   function automatic rr_pick_t rr_next(input logic [RR_MAX-1:0] req,
                                        input int unsigned       last,
                                        input int unsigned       n);
      rr_pick_t    p;
      int unsigned c;
      p = '0;
      for (int k = RR_MAX; k >= 1; k--) begin
         if (k <= int'(n)) begin
            c = (last + k) % n;
            if (req[c]) begin
               p.hit = 1'b1;
               p.idx = 3'(c);
            end
         end
      end
      return p;
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/palin_rr_arb.sv
// rtl/palin_rr_arb.sv - combinational round-robin pick among NREQ requesters
module palin_rr_arb import palin_pkg::*; #(
   parameter int NREQ = 2,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   last_i,
   output logic            hit_o,
   output logic [IW-1:0]   idx_o
);

   rr_pick_t          pick;
   logic [RR_MAX-1:0] req_ext;

   always_comb begin
      req_ext           = '0;
      req_ext[NREQ-1:0] = req_i;
      pick              = rr_next(req_ext, 32'(last_i), NREQ);
      hit_o             = pick.hit;
      idx_o             = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick.idx == 3'(i)) idx_o = IW'(i);
      end
   end

endmodule

// File: rtl/palin_check_sched.sv
// rtl/palin_check_sched.sv - shares one palindrome checker core between NREQ requesters
// Optional statistics counters enabled by defining PALIN_SCHED_STATS_EN.
module palin_check_sched import palin_pkg::*; #(
   parameter int NREQ    = 2,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*DATA_W-1:0]  req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         rsp_valid,
   input  logic [NREQ-1:0]         rsp_ready,
   output logic                    rsp_is_pal,
   output logic                    rsp_timeout,
   output logic                    core_start,
   output logic [DATA_W-1:0]       core_data,
   input  logic                    core_done,
   input  logic                    core_is_pal,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id
`ifdef PALIN_SCHED_STATS_EN
   ,
   output logic [STAT_W-1:0]       stat_checks,
   output logic [STAT_W-1:0]       stat_pal,
   output logic [STAT_W-1:0]       stat_timeouts
`endif
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT) + 1;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [GW-1:0]     gid_q, gid_d;
   logic [GW-1:0]     last_q, last_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              pal_q, pal_d;
   logic              to_q, to_d;
   logic              arb_hit;
   logic [GW-1:0]     arb_idx;
   logic              rsp_hs;

   palin_rr_arb #(.NREQ(NREQ), .IW(GW)) u_arb (
      .req_i  (req_valid),
      .last_i (last_q),
      .hit_o  (arb_hit),
      .idx_o  (arb_idx)
   );

   assign rsp_hs = (state_q == ST_RESP) && rsp_ready[gid_q];

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      gid_d     = gid_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      pal_d     = pal_q;
      to_d      = to_q;
      req_ready = '0;
      case (state_q)
         ST_IDLE: begin
            if (arb_hit) begin
               req_ready[arb_idx] = 1'b1;
               data_d             = req_data[int'(arb_idx)*DATA_W +: DATA_W];
               gid_d              = arb_idx;
               state_d            = ST_START;
            end
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // A done arriving on the limit cycle still counts as a real result.
            if (core_done) begin
               pal_d   = core_is_pal;
               to_d    = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               pal_d   = 1'b0;
               to_d    = 1'b1;
               state_d = ST_RESP;
            end
         end
         default: begin
            if (rsp_hs) begin
               last_d  = gid_q;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         gid_q   <= '0;
         last_q  <= GW'(NREQ - 1);
         cnt_q   <= '0;
         pal_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         pal_q   <= pal_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (state_q == ST_RESP) rsp_valid[gid_q] = 1'b1;
   end

   assign rsp_is_pal  = pal_q;
   assign rsp_timeout = to_q;
   assign core_start  = (state_q == ST_START);
   assign core_data   = data_q;
   assign busy        = (state_q != ST_IDLE);
   assign grant_id    = gid_q;

`ifdef PALIN_SCHED_STATS_EN
   logic [STAT_W-1:0] checks_q, spal_q, sto_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         checks_q <= '0;
         spal_q   <= '0;
         sto_q    <= '0;
      end else if (rsp_hs) begin
         checks_q <= sat_inc(checks_q);
         if (pal_q) spal_q <= sat_inc(spal_q);
         if (to_q)  sto_q  <= sat_inc(sto_q);
      end
   end

   assign stat_checks   = checks_q;
   assign stat_pal      = spal_q;
   assign stat_timeouts = sto_q;
`endif

endmodule

// File: doc/palin_check_sched.md
Name: palin_check_sched

Overview:
- Scheduler that shares one CheckPalindrome checker core between NREQ requesters.
- Requesters are the AXI4-Lite register front-end and a stream feeder.
- Round-robin arbitration; latches the granted word; pulses the core start; waits for done with a bounded timeout; returns the result to the owning requester.
- Sits between the requester-side logic and the checker core inside the CheckPalindrome IP.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DATA_W, 32, width of the word checked (matches the 32-bit register width).
- TIMEOUT, 64, max cycles in WAIT before the check is abandoned (>=2).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_data  in  NREQ*DATA_W  packed request words; slice i belongs to requester i.
- req_ready  out  NREQ  one-hot accept.
- rsp_valid  out  NREQ  one-hot result valid.
- rsp_ready  in  NREQ  per-requester result accept.
- rsp_is_pal  out  1  result bit, shared, qualified by rsp_valid.
- rsp_timeout  out  1  result flag, shared, qualified by rsp_valid.
- core_start  out  1  one-cycle start pulse to the core.
- core_data  out  DATA_W  word under test; stable from START until leaving WAIT.
- core_done  in  1  core completion pulse.
- core_is_pal  in  1  core result, valid with core_done.
- busy  out  1  high in every state except IDLE.
- grant_id  out  clog2(NREQ)  index of the current owner.

Behaviour:
- Reset values:
  - All outputs 0.
  - State is IDLE, wait counter is 0.
  - last_grant = NREQ-1, so requester 0 wins first.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - Search req_valid starting at (last_grant+1) mod NREQ, wrapping.
  - On a hit g, req_ready[g]=1 combinationally in that same cycle. The handshake completes in that cycle.
  - In that cycle, latch req_data slice g into core_data and latch g into grant_id, then go to START.
  - No req_valid: req_ready stays 0 and the FSM stays in IDLE.
- START:
  - core_start=1 for exactly one cycle.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - core_done=1: capture core_is_pal into rsp_is_pal, rsp_timeout=0, go to RESP.
  - Counter == TIMEOUT-1 with no done: rsp_is_pal=0, rsp_timeout=1, go to RESP.
  - core_done in the same cycle as the counter limit: done wins, no timeout.
- RESP:
  - rsp_valid[grant_id]=1; rsp_is_pal and rsp_timeout held stable.
  - Hold until rsp_ready[grant_id]=1. In that cycle, drop rsp_valid, set last_grant=grant_id, go to IDLE.
  - rsp_ready on any other index is ignored.
- core_done outside WAIT is ignored, including a late done after a timeout.
- Latency, request accept to rsp_valid: 2 + core latency cycles, minimum 3.
- Back-to-back: the next grant can happen in the first IDLE cycle after the response handshake. There is no bubble beyond that IDLE cycle.
- Fairness: a requester holding req_valid is granted within NREQ transactions.
- Reset asserted mid-operation:
  - Abort immediately, no response for the aborted request.
  - core_start=0 on the next edge; all state back to reset values.

Optional Feature:
- Macro: PALIN_SCHED_STATS_EN.
- Defined: adds three 16-bit saturating counters, cleared by ARESET, that increment on the RESP handshake cycle:
  - stat_checks  out  16  every completed check.
  - stat_pal  out  16  rsp_is_pal=1.
  - stat_timeouts  out  16  rsp_timeout=1.
- Counters hold at 0xFFFF.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package palin_pkg holds:
  - the state enum typedef;
  - STAT_W=16;
  - a function for round-robin next-index selection.
- Sub-module palin_rr_arb: request vector plus last_grant in; hit flag and index out; purely combinational.
- The FSM, latches and timeout counter stay in palin_check_sched.

Test Plan:
- Single request, fast core:
  - Stimulus: req 0 with 0x00011000; core_done with is_pal=1 two cycles after start.
  - Response: one core_start pulse with core_data=0x00011000; rsp_valid[0] 4 cycles after accept; rsp_is_pal=1, rsp_timeout=0.
- Contention:
  - Stimulus: req 0 and req 1 both held continuously for 4 transactions.
  - Response: grant order 0,1,0,1; no requester is granted twice in a row.
- Timeout:
  - Stimulus: core never asserts done; TIMEOUT=64.
  - Response: rsp_valid exactly 64 cycles after entering WAIT; rsp_timeout=1, rsp_is_pal=0. A done pulse 10 cycles later is ignored and the FSM stays in IDLE.
- Done at the limit:
  - Stimulus: core_done=1, is_pal=1 in the cycle the counter reaches 63.
  - Response: rsp_timeout=0, rsp_is_pal=1.
- Response backpressure plus reset:
  - Stimulus: rsp_ready held 0 for 20 cycles, then ARESET for 1 cycle.
  - Response: rsp_valid and rsp_is_pal stable for all 20 cycles. The edge after reset shows all outputs 0, busy=0, and the next grant goes to requester 0.
- Stats (macro defined):
  - Stimulus: 3 palindromes, 1 non-palindrome, 1 timeout.
  - Response: stat_checks=5, stat_pal=3, stat_timeouts=1.
  - Separately, 0x10000 checks leave stat_checks at 0xFFFF.
